// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_RF = 2'b00;
    localparam fwd_t FWD_W  = 2'b01;
    localparam fwd_t FWD_M  = 2'b10;

    localparam int unsigned DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of hazard inputs and stall/flush/forward/counter outputs.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic                      RegWriteM, RegWriteW, LoadE, PCSrcE;
    logic                      MemReqM, MemReadyM;
    logic                      StallF, StallD, StallE, StallM;
    logic                      FlushD, FlushE, FlushW;
    fwd_t                      ForwardAE, ForwardBE;
    logic                      MemErr;
    logic [DATA_WIDTH-1:0]     StallCnt, FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forward select for one E-stage source operand; M result beats W result.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      regwrite_m,
    input  logic                      regwrite_w,
    output fwd_t                      fwd
);
    always_comb begin
        fwd = FWD_RF;
        if (regwrite_m && rd_m != '0 && rd_m == rs)
            fwd = FWD_M;
        else if (regwrite_w && rd_w != '0 && rd_w == rs)
            fwd = FWD_W;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing, forwarding and memory-wait timeout for the 5-stage core.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT    = DEF_MEM_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  mem_err;
    logic [DATA_WIDTH-1:0] stall_cnt, flush_cnt;
    logic                  lu, hold, timeout;
    logic                  stall_fd, stall_em, flush_d, flush_e, flush_w;
    fwd_t                  fwd_a, fwd_b;

    fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs(hz.Rs1E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .regwrite_m(hz.RegWriteM), .regwrite_w(hz.RegWriteW), .fwd(fwd_a)
    );

    fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs(hz.Rs2E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .regwrite_m(hz.RegWriteM), .regwrite_w(hz.RegWriteW), .fwd(fwd_b)
    );

    assign lu = hz.LoadE && hz.RdE != '0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);

    // Wait rules apply from the first unready cycle, including the RUN entry cycle.
    assign hold    = (state == MEM_WAIT) ? !hz.MemReadyM : (hz.MemReqM && !hz.MemReadyM);
    assign timeout = hold && (wait_cnt == CNT_LAST);

    always_comb begin
        stall_fd = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_w  = 1'b0;
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (hold) begin
            stall_fd = 1'b1;
            stall_em = 1'b1;
            flush_w  = 1'b1;
        end else begin
            stall_fd = lu && !hz.PCSrcE;
            flush_d  = hz.PCSrcE;
            flush_e  = hz.PCSrcE || lu;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + DATA_WIDTH'(stall_fd);
            flush_cnt <= flush_cnt + DATA_WIDTH'(flush_d || flush_e);
            if (timeout) begin
                mem_err  <= 1'b1;
                state    <= RUN;
                wait_cnt <= '0;
            end else if (hold) begin
                state    <= MEM_WAIT;
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                state    <= RUN;
                wait_cnt <= '0;
            end
        end
    end

    assign hz.StallF    = stall_fd;
    assign hz.StallD    = stall_fd;
    assign hz.StallE    = stall_em;
    assign hz.StallM    = stall_em;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushW    = flush_w;
    assign hz.ForwardAE = rst ? fwd_a : FWD_RF;
    assign hz.ForwardBE = rst ? fwd_b : FWD_RF;
    assign hz.MemErr    = mem_err;
    assign hz.StallCnt  = stall_cnt;
    assign hz.FlushCnt  = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations (MEM_TIMEOUT = 4).
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    hazard_ctrl_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) hz ();

    hazard_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0;
        hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    endtask

    task automatic chk_stalls(input string tag, input logic fd, input logic em);
        chk({tag, "_StallF"}, hz.StallF, fd);
        chk({tag, "_StallD"}, hz.StallD, fd);
        chk({tag, "_StallE"}, hz.StallE, em);
        chk({tag, "_StallM"}, hz.StallM, em);
    endtask

    task automatic chk_flush(input string tag, input logic d, input logic e, input logic w);
        chk({tag, "_FlushD"}, hz.FlushD, d);
        chk({tag, "_FlushE"}, hz.FlushE, e);
        chk({tag, "_FlushW"}, hz.FlushW, w);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle();
        // Forwarding would match, but reset forces it to register file.
        hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd5; hz.PCSrcE = 1'b1;
        #2;
        chk_stalls("rst", 1'b0, 1'b0);
        chk_flush("rst", 1'b1, 1'b1, 1'b1);
        chk("rst_FwdA", hz.ForwardAE, 2'b00);
        chk("rst_MemErr", hz.MemErr, 1'b0);
        chk("rst_StallCnt", hz.StallCnt, 32'd0);
        chk("rst_FlushCnt", hz.FlushCnt, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        #1;
        chk_flush("rel", 1'b0, 1'b0, 1'b0);
        chk_stalls("rel", 1'b0, 1'b0);

        // Forwarding priority and x0
        cyc();
        hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd0;
        #1;
        chk("fwd_m_A", hz.ForwardAE, 2'b10);
        chk("fwd_m_B", hz.ForwardBE, 2'b00);
        cyc();
        hz.RegWriteM = 1'b0; hz.Rs2E = 5'd5;
        #1;
        chk("fwd_w_A", hz.ForwardAE, 2'b01);
        chk("fwd_w_B", hz.ForwardBE, 2'b01);
        cyc();
        hz.RegWriteM = 1'b1; hz.RdM = 5'd0; hz.RdW = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
        #1;
        chk("fwd_x0_A", hz.ForwardAE, 2'b00);
        chk("fwd_x0_B", hz.ForwardBE, 2'b00);
        cyc();
        hz.RdM = 5'd3; hz.RdW = 5'd3; hz.Rs2E = 5'd3;
        #1;
        chk("fwd_prio_B", hz.ForwardBE, 2'b10);
        chk("fwd_prio_A", hz.ForwardAE, 2'b00);

        // Load-use stall, then load-use under a taken branch
        cyc();
        idle();
        hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        chk_stalls("lu", 1'b1, 1'b0);
        chk_flush("lu", 1'b0, 1'b1, 1'b0);
        cyc();
        idle();
        #1;
        chk("lu_end_StallF", hz.StallF, 1'b0);
        chk("lu_StallCnt", hz.StallCnt, 32'd1);
        chk("lu_FlushCnt", hz.FlushCnt, 32'd1);
        cyc();
        hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.PCSrcE = 1'b1;
        #1;
        chk_stalls("lubr", 1'b0, 1'b0);
        chk_flush("lubr", 1'b1, 1'b1, 1'b0);
        cyc();
        idle();
        hz.LoadE = 1'b1; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
        #1;
        chk("lux0_StallF", hz.StallF, 1'b0);
        chk("lux0_FlushE", hz.FlushE, 1'b0);
        chk("lubr_StallCnt", hz.StallCnt, 32'd1);
        chk("lubr_FlushCnt", hz.FlushCnt, 32'd2);

        // Memory wait of three cycles with a branch deferred until ready
        cyc();
        idle();
        hz.MemReqM = 1'b1;
        #1;
        chk_stalls("mw1", 1'b1, 1'b1);
        chk_flush("mw1", 1'b0, 1'b0, 1'b1);
        cyc();
        hz.PCSrcE = 1'b1;
        #1;
        chk_stalls("mw2", 1'b1, 1'b1);
        chk_flush("mw2", 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        chk_stalls("mw3", 1'b1, 1'b1);
        chk_flush("mw3", 1'b0, 1'b0, 1'b1);
        cyc();
        hz.MemReadyM = 1'b1;
        #1;
        chk_stalls("mwrdy", 1'b0, 1'b0);
        chk_flush("mwrdy", 1'b1, 1'b1, 1'b0);
        chk("mwrdy_StallCnt", hz.StallCnt, 32'd4);
        cyc();
        idle();
        #1;
        chk_flush("mwpost", 1'b0, 1'b0, 1'b0);
        chk("mwpost_StallCnt", hz.StallCnt, 32'd4);
        chk("mwpost_FlushCnt", hz.FlushCnt, 32'd3);
        chk("mwpost_MemErr", hz.MemErr, 1'b0);

        // Timeout after four unready cycles
        cyc();
        hz.MemReqM = 1'b1;
        #1;
        chk_stalls("to1", 1'b1, 1'b1);
        cyc();
        cyc();
        cyc();
        #1;
        chk_stalls("to4", 1'b1, 1'b1);
        chk("to4_MemErr", hz.MemErr, 1'b0);
        cyc();
        hz.MemReqM = 1'b0;
        #1;
        chk("to_MemErr", hz.MemErr, 1'b1);
        chk_stalls("to_run", 1'b0, 1'b0);
        chk("to_StallCnt", hz.StallCnt, 32'd8);
        cyc();
        #1;
        chk("to_sticky", hz.MemErr, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst2_MemErr", hz.MemErr, 1'b0);
        chk("rst2_StallCnt", hz.StallCnt, 32'd0);
        chk_flush("rst2", 1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Ready on the fourth cycle wins over timeout
        cyc();
        hz.MemReqM = 1'b1;
        cyc();
        cyc();
        cyc();
        hz.MemReadyM = 1'b1;
        #1;
        chk_stalls("rdy4", 1'b0, 1'b0);
        cyc();
        idle();
        #1;
        chk("rdy4_MemErr", hz.MemErr, 1'b0);
        chk("rdy4_StallCnt", hz.StallCnt, 32'd3);
        chk("rdy4_FlushCnt", hz.FlushCnt, 32'd0);

        // Reset during MEM_WAIT aborts the wait
        cyc();
        hz.MemReqM = 1'b1;
        cyc();
        #1;
        chk_stalls("abrt_wait", 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        chk_stalls("abrt_rst", 1'b0, 1'b0);
        chk("abrt_FlushW", hz.FlushW, 1'b1);
        hz.MemReqM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_stalls("abrt_run", 1'b0, 1'b0);
        chk("abrt_FlushW_run", hz.FlushW, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
